// File: rtl/alu_share_arbiter.sv
// Two-client round-robin arbiter and sequencer in front of a shared ALU.
// One operation in flight at a time: accept (IDLE) -> evaluate (ISSUE) ->
// hold the response for its owner (RESP) until that owner accepts it.
//
// Handshakes: a transfer happens on a rising CLK edge where valid and ready
// are both high. Requesters hold valid and payload stable until ready is
// seen. A requester may drop valid before acceptance without side effects.
// Responses hold rsp_data/rsp_zero stable for as long as rspN_valid is high.
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic [4:0]       req0_sa,
  input  logic             req0_usesa,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  input  logic [4:0]       req1_sa,
  input  logic             req1_usesa,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  input  logic             rsp0_ready,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  output logic [4:0]       alu_sa,
  output logic             alu_srca,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic last;       // most recently served client
  logic owner;      // client owning the in-flight operation
  logic rsp_valid;  // response pending for owner
  logic grant;      // client selected this cycle (valid only when any_req)
  logic any_req;
  logic accept;
  logic owner_ready;

  // Round-robin grant: on a tie the client that was not served last wins.
  always_comb begin
    grant   = 1'b0;
    any_req = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant = ~last;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign accept      = (state == IDLE) && any_req;
  assign req0_ready  = (state == IDLE) && (grant == 1'b0) && req0_valid;
  assign req1_ready  = (state == IDLE) && (grant == 1'b1) && req1_valid;
  assign owner_ready = owner ? rsp1_ready : rsp0_ready;

  assign rsp0_valid  = rsp_valid && (owner == 1'b0);
  assign rsp1_valid  = rsp_valid && (owner == 1'b1);
  assign busy        = (state != IDLE);
  assign dbg_state   = state;

  // Next-state logic for the issue/response sequence.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   state_next = RESP;
      RESP:    if (owner_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand latch on acceptance, result capture in ISSUE, release in RESP.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      last      <= 1'b1;
      owner     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= 3'd0;
      alu_sa    <= 5'd0;
      alu_srca  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner <= grant;
            if (grant == 1'b0) begin
              // With usesa the A operand becomes the zero-extended shift amount.
              alu_a    <= req0_usesa ? WIDTH'(req0_sa) : req0_a;
              alu_b    <= req0_b;
              alu_op   <= req0_op;
              alu_sa   <= req0_sa;
              alu_srca <= req0_usesa;
            end else begin
              alu_a    <= req1_usesa ? WIDTH'(req1_sa) : req1_a;
              alu_b    <= req1_b;
              alu_op   <= req1_op;
              alu_sa   <= req1_sa;
              alu_srca <= req1_usesa;
            end
          end
        end
        ISSUE: begin
          rsp_data  <= alu_result;
          rsp_zero  <= alu_zero;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (owner_ready) begin
            rsp_valid <= 1'b0;
            last      <= owner;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU attached.
module tb_alu_share_arbiter;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         Reset;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]   req0_op, req1_op;
  logic [4:0]   req0_sa, req1_sa;
  logic         req0_usesa, req1_usesa;
  logic         rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_zero;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [2:0]   alu_op;
  logic [4:0]   alu_sa;
  logic         alu_srca, alu_zero, busy;
  logic [1:0]   dbg_state;

  int errors = 0;
  int checks = 0;

  alu_share_arbiter #(.WIDTH(W)) dut (
    .CLK(CLK), .Reset(Reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_sa(req0_sa), .req0_usesa(req0_usesa),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_sa(req1_sa), .req1_usesa(req1_usesa),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_sa(alu_sa), .alu_srca(alu_srca),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Clock.
  always #5 CLK = ~CLK;

  // Behavioural ALU: B shifted left by A for op 010.
  always_comb begin
    case (alu_op)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      3'b010:  alu_result = alu_b << alu_a[4:0];
      3'b011:  alu_result = alu_a | alu_b;
      3'b100:  alu_result = alu_a & alu_b;
      3'b101:  alu_result = {31'd0, (alu_a < alu_b)};
      3'b110:  alu_result = {31'd0, ($signed(alu_a) < $signed(alu_b))};
      default: alu_result = alu_a ^ alu_b;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0; req0_sa = 0; req0_usesa = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0; req1_sa = 0; req1_usesa = 0;
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  task automatic do_reset();
    Reset = 1;
    step();
    step();
    Reset = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, W'(dbg_state), 0);
    chk({tag, "_busy"}, W'(busy), 0);
    chk({tag, "_rsp0v"}, W'(rsp0_valid), 0);
    chk({tag, "_rsp1v"}, W'(rsp1_valid), 0);
    chk({tag, "_data"}, rsp_data, 0);
    chk({tag, "_zero"}, W'(rsp_zero), 0);
    chk({tag, "_alu_a"}, alu_a, 0);
    chk({tag, "_alu_b"}, alu_b, 0);
    chk({tag, "_alu_op"}, W'(alu_op), 0);
    chk({tag, "_alu_sa"}, W'(alu_sa), 0);
    chk({tag, "_srca"}, W'(alu_srca), 0);
  endtask

  initial begin
    logic [W-1:0] exp_data;
    logic         exp_zero;
    logic         g;
    clear_inputs();
    Reset = 1;
    step();
    do_reset();
    chk_reset_vals("reset");

    // Test 1: client 0 add 5+7.
    req0_a = 5; req0_b = 7; req0_op = 3'b000; req0_valid = 1; rsp0_ready = 1;
    #1;
    chk("t1_req0_ready", W'(req0_ready), 1);
    chk("t1_req1_ready", W'(req1_ready), 0);
    step(); req0_valid = 0;
    chk("t1_busy_issue", W'(busy), 1);
    chk("t1_alu_a", alu_a, 5);
    chk("t1_alu_b", alu_b, 7);
    chk("t1_rsp0v_issue", W'(rsp0_valid), 0);
    step();
    chk("t1_rsp0v", W'(rsp0_valid), 1);
    chk("t1_data", rsp_data, 12);
    chk("t1_zero", W'(rsp_zero), 0);
    step();
    chk("t1_busy_done", W'(busy), 0);
    chk("t1_rsp0v_done", W'(rsp0_valid), 0);

    // Test 2: client 1 sub 9-9 -> zero.
    rsp0_ready = 0;
    req1_a = 9; req1_b = 9; req1_op = 3'b001; req1_valid = 1; rsp1_ready = 1;
    #1;
    chk("t2_req1_ready", W'(req1_ready), 1);
    step(); req1_valid = 0;
    chk("t2_rsp0v_issue", W'(rsp0_valid), 0);
    step();
    chk("t2_rsp1v", W'(rsp1_valid), 1);
    chk("t2_rsp0v", W'(rsp0_valid), 0);
    chk("t2_data", rsp_data, 0);
    chk("t2_zero", W'(rsp_zero), 1);
    step();
    chk("t2_rsp1v_done", W'(rsp1_valid), 0);
    chk("t2_rsp0v_done", W'(rsp0_valid), 0);

    // Test 3: both clients valid continuously from reset -> 0,1,0,1.
    do_reset();
    req0_a = 3; req0_b = 4; req0_op = 3'b011;   // or  -> 7
    req1_a = 6; req1_b = 3; req1_op = 3'b111;   // xor -> 5
    req0_valid = 1; req1_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
    #1;
    for (int i = 0; i < 4; i++) begin
      g = i[0];
      chk($sformatf("t3_op%0d_req0_ready", i), W'(req0_ready), W'(!g));
      chk($sformatf("t3_op%0d_req1_ready", i), W'(req1_ready), W'(g));
      step();
      chk($sformatf("t3_op%0d_ready_issue", i), W'(req0_ready | req1_ready), 0);
      step();
      exp_data = g ? 32'd5 : 32'd7;
      chk($sformatf("t3_op%0d_rsp0v", i), W'(rsp0_valid), W'(!g));
      chk($sformatf("t3_op%0d_rsp1v", i), W'(rsp1_valid), W'(g));
      chk($sformatf("t3_op%0d_data", i), rsp_data, exp_data);
      step();
    end
    req0_valid = 0; req1_valid = 0;

    // Test 4: shift with A taken from sa.
    req0_a = 32'hFFFF_FFFF; req0_b = 1; req0_op = 3'b010; req0_sa = 4; req0_usesa = 1;
    req0_valid = 1;
    #1;
    chk("t4_req0_ready", W'(req0_ready), 1);
    step(); req0_valid = 0; req0_usesa = 0; req0_sa = 0;
    chk("t4_alu_a", alu_a, 4);
    chk("t4_srca", W'(alu_srca), 1);
    chk("t4_alu_sa", W'(alu_sa), 4);
    step();
    chk("t4_rsp0v", W'(rsp0_valid), 1);
    chk("t4_data", rsp_data, 16);
    step();

    // Test 5: back-pressure on client 0 while client 1 waits.
    rsp0_ready = 0;
    req0_a = 100; req0_b = 23; req0_op = 3'b000; req0_valid = 1;
    #1;
    chk("t5_req0_ready", W'(req0_ready), 1);
    step(); req0_valid = 0;
    req1_a = 32'hF0; req1_b = 32'h0F; req1_op = 3'b100; req1_valid = 1;
    #1;
    chk("t5_req1_ready_issue", W'(req1_ready), 0);
    step();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t5_hold%0d_rsp0v", i), W'(rsp0_valid), 1);
      chk($sformatf("t5_hold%0d_data", i), rsp_data, 123);
      chk($sformatf("t5_hold%0d_req1_ready", i), W'(req1_ready), 0);
      chk($sformatf("t5_hold%0d_busy", i), W'(busy), 1);
      step();
    end
    rsp0_ready = 1;
    #1;
    chk("t5_complete_rsp0v", W'(rsp0_valid), 1);
    chk("t5_complete_data", rsp_data, 123);
    chk("t5_complete_req1_ready", W'(req1_ready), 0);
    step(); rsp0_ready = 0;
    chk("t5_req1_ready_after", W'(req1_ready), 1);
    chk("t5_rsp0v_after", W'(rsp0_valid), 0);
    step(); req1_valid = 0;
    step();
    chk("t5_rsp1v", W'(rsp1_valid), 1);
    chk("t5_data1", rsp_data, 0);
    chk("t5_zero1", W'(rsp_zero), 1);
    rsp1_ready = 1;
    step();
    chk("t5_idle", W'(dbg_state), 0);

    // Test 6a: reset during RESP discards the response.
    rsp0_ready = 0; rsp1_ready = 0;
    req0_a = 1; req0_b = 2; req0_op = 3'b000; req0_valid = 1;
    #1;
    chk("t6a_req0_ready", W'(req0_ready), 1);
    step(); req0_valid = 0;
    step();
    chk("t6a_rsp0v_before", W'(rsp0_valid), 1);
    chk("t6a_data_before", rsp_data, 3);
    Reset = 1;
    step();
    chk_reset_vals("t6a");
    Reset = 0; rsp0_ready = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t6a_post%0d_rsp0v", i), W'(rsp0_valid), 0);
      chk($sformatf("t6a_post%0d_busy", i), W'(busy), 0);
    end

    // Test 6b: reset during ISSUE discards the operation.
    rsp0_ready = 0; rsp1_ready = 1;
    req1_a = 5; req1_b = 5; req1_op = 3'b000; req1_valid = 1;
    #1;
    chk("t6b_req1_ready", W'(req1_ready), 1);
    step(); req1_valid = 0;
    chk("t6b_state_issue", W'(dbg_state), 1);
    Reset = 1;
    step();
    chk_reset_vals("t6b");
    Reset = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t6b_post%0d_rsp1v", i), W'(rsp1_valid), 0);
      chk($sformatf("t6b_post%0d_data", i), rsp_data, 0);
    end

    // After the reset, a tie goes to client 0 again.
    req0_a = 2; req0_b = 5; req0_op = 3'b110;  // 2 < 5 signed -> 1
    req1_a = 2; req1_b = 5; req1_op = 3'b001;
    req0_valid = 1; req1_valid = 1; rsp0_ready = 1;
    #1;
    chk("t7_tie_req0_ready", W'(req0_ready), 1);
    chk("t7_tie_req1_ready", W'(req1_ready), 0);
    step(); req0_valid = 0; req1_valid = 0;
    step();
    exp_zero = 1'b0;
    chk("t7_rsp0v", W'(rsp0_valid), 1);
    chk("t7_data", rsp_data, 1);
    chk("t7_zero", W'(rsp_zero), W'(exp_zero));
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Two-requester arbiter and sequencer in front of the shared 32-bit ALU. It accepts operation requests from two independent clients (e.g. main datapath and address/branch unit), grants the ALU round-robin, and drives the ALU operand, opcode and shift-amount inputs from latched registers. It captures the ALU's result and zero flag and returns them to the owning client through a valid/ready response handshake. It sits between the clients and the ALU. The ALU's immediate-select input is tied to register-operand mode outside this block.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must match the ALU.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  client 0 request valid.
- req0_ready  out  1  client 0 request accepted this cycle.
- req0_a, req0_b  in  WIDTH  client 0 operands A and B.
- req0_op  in  3  client 0 ALU opcode (000 add, 001 sub, 010 B<<A, 011 or, 100 and, 101 unsigned-lt form, 110 signed lt, 111 xor).
- req0_sa  in  5  client 0 shift amount.
- req0_usesa  in  1  1: ALU A operand = zero-extended sa.
- req1_*  same as req0_*, for client 1.
- rsp0_valid, rsp1_valid  out  1  response valid to client 0 / 1.
- rsp0_ready, rsp1_ready  in  1  client accepts response.
- rsp_data  out  WIDTH  captured ALU result (shared by both clients; qualified by rspN_valid).
- rsp_zero  out  1  captured ALU zero flag.
- alu_a, alu_b  out  WIDTH  to ALU ReadData1 / ReadData2.
- alu_op  out  3  to ALU opcode.
- alu_sa  out  5  to ALU shift amount.
- alu_srca  out  1  to ALU A-source select.
- alu_result  in  WIDTH  from ALU, combinational.
- alu_zero  in  1  from ALU, combinational.
- busy  out  1  high whenever state != IDLE.

## Operation
- FSM states:
  - IDLE: no client owns the ALU.
  - ISSUE: the ALU is evaluating the latched request.
  - RESP: the response is held for the owner.
- Arbitration in IDLE: `last` records the most recently served client.
  - If both clients are valid, grant goes to the client other than `last`.
  - If only one client is valid, it wins.
  - Grant is combinational. `reqN_ready = (state==IDLE) && grant==N && reqN_valid`.
- IDLE → ISSUE on an accepted request.
  - Latch a, b, op, sa and usesa into the alu_* registers.
  - Set `owner` = N.
- ISSUE → RESP unconditionally.
  - Capture alu_result into rsp_data and alu_zero into rsp_zero.
  - Assert rsp<owner>_valid.
- RESP → IDLE when rsp<owner>_ready is high.
  - Clear rsp<owner>_valid.
  - Set `last` = owner.
- rsp_valid of the non-owner is always 0.
- alu_* outputs hold their last latched value outside ISSUE. They change only on acceptance.
- Requests presented in ISSUE or RESP are not accepted. Ready stays low and the client must hold its request.
- A client may drop valid before acceptance without effect.
- Reset values:
  - state = IDLE, `last` = 1 (client 0 wins the first tie), owner = 0.
  - All alu_* outputs = 0, rsp_data = 0, rsp_zero = 0.
  - rspN_valid = 0, busy = 0.
- Reset in any state aborts the operation. The in-flight request and response are discarded, and no response is ever issued for them.

## Timing
- Accept in cycle N → ALU evaluates in N+1 → rsp valid from N+2.
- If rsp_ready is high in N+2, the response completes in N+2, IDLE is reached at N+3, and a new accept is possible in N+3.
- Minimum 3 cycles per operation; no pipelining.
- The ALU path alu_* → alu_result must settle within one CLK period.
- rsp_data and rsp_zero are stable for the whole time rsp valid is high.
- Back-pressure: rsp_ready held low keeps the FSM in RESP indefinitely. busy stays 1 and both req ready signals stay 0.
- Reset has priority over every transition in the same edge.

## Test plan
- After reset, req0 {a=5, b=7, op=000}, rsp0_ready=1 → req0_ready in cycle 0; rsp0_valid in cycle 2 with rsp_data=12, rsp_zero=0; busy back to 0 in cycle 3.
- req1 {a=9, b=9, op=001} → rsp1_valid with rsp_data=0, rsp_zero=1; rsp0_valid stays 0 throughout.
- req0 and req1 both valid continuously from reset, with different ops → grants strictly alternate 0,1,0,1; each response goes to the correct client.
- req0 {usesa=1, sa=4, b=1, op=010, a=0xFFFFFFFF} → alu_a=4, alu_srca=1, rsp_data=16.
- rsp0_ready held low 5 cycles after rsp0_valid, with req1 valid → rsp_data constant, req1_ready=0 throughout; req1 is accepted in the cycle after rsp0 completes.
- Reset asserted during RESP (and, in a second run, during ISSUE) → next cycle: state IDLE, rsp valid=0, all outputs at reset values, no stale response afterwards.
